ram_march_bist: RTL and testbench
=================================

# ram_march_bist

Built-in self-test engine that drives the single-port LUT RAM interface as its initiator. It runs a March C- sequence over every address, compares each read against the expected background and reports pass/fail, the first failing address and a bit syndrome. It sits between the RAM and the system controller and owns the RAM port while `busy` is high.

## Interface
- `WIDTH`, 32: RAM data width.
- `DEPTH`, 2048: RAM words; address width `AW = $clog2(DEPTH)`.
- `PATTERN`, 32'h0000_0000: data background "0"; background "1" is `~PATTERN`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `busy`  out  1  high while the test owns the RAM.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  high at completion if no mismatch occurred; held until next `start`.
- `fail_addr`  out  AW  address of the first mismatch.
- `fail_syndrome`  out  WIDTH  expected XOR actual at the first mismatch.
- `fail_count`  out  16  number of mismatching reads, saturating at 16'hFFFF.
- `ram_write_read_en`  out  1  0 = write, 1 = read.
- `ram_address`  out  AW  RAM address.
- `ram_din`  out  WIDTH  write data.
- `ram_dout`  in  WIDTH  RAM read data, registered, valid the cycle after the read address is presented.

## Operation
- States: IDLE, RUN, CHECK, DONE.
- March C- elements in order, where ⇑ means addresses 0 to DEPTH-1 and ⇓ means DEPTH-1 to 0:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇓(r0)
- In r/w elements each address takes 2 cycles: read, then write to the same address.
- Elements run back to back with no idle cycles: 10·DEPTH operation cycles in total.
- Address counters stop at the end of their range; they never wrap. ⇓ ends at 0 without underflow.
- Compare pipeline: on each read, the expected value and address are registered. The compare happens the next cycle against `ram_dout`, overlapping the following write or read.
- After the last M5 read, the FSM goes to CHECK for one cycle, which performs the final compare, then to DONE.
- Mismatch handling:
  - `pass` is cleared and stays cleared.
  - `fail_count` increments.
  - `fail_addr` and `fail_syndrome` are captured on the first mismatch only.
- DONE lasts one cycle: `done`=1 and `busy`=0, then the FSM returns to IDLE.
- `start` while not in IDLE is ignored. A new `start` clears `pass`→1, `fail_count`, `fail_addr` and `fail_syndrome`.
- Reset mid-test aborts immediately: all outputs return to reset values and RAM contents are undefined.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_syndrome`=0, `fail_count`=0, `ram_write_read_en`=1, `ram_address`=0, `ram_din`=0.
- All outputs are registered.
- `start` sampled at edge k: `busy`=1 and the first M0 write are driven from edge k+1.
- The last M5 read is driven in cycle k+10·DEPTH. CHECK occurs in the following cycle.
- `done` is high for exactly one cycle, 10·DEPTH+2 cycles after edge k (162 for DEPTH=16).
- `pass` is valid when `done` is high.
- `ram_*` outputs are held at reset values whenever `busy`=0.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined: the first mismatch sends the FSM straight to DONE. `done` pulses the cycle after the mismatching compare, `fail_count`=1 and the remaining elements are skipped.
- `BIST_STOP_ON_FAIL_EN` undefined: the full sequence always runs and every mismatch is counted.

## Structure
- Package `ram_bist_pkg` holds:
  - the state enum;
  - the march element table, giving direction, read value and write value per element;
  - the op encodings `OP_WRITE=0` and `OP_READ=1`.
- Sub-module `ram_bist_checker` holds the compare stage:
  - it registers expected data and address;
  - it drives `pass`, `fail_addr`, `fail_syndrome` and `fail_count`.
- The top level holds the FSM and the address and element counters.

## Test plan
- DEPTH=16, fault-free registered RAM model, `start` pulse → `done` exactly 162 cycles later, `pass`=1, `fail_count`=0.
- Model with bit 3 of address 5 stuck-at-1 → `pass`=0, `fail_addr`=5, `fail_syndrome`=32'h0000_0008, `fail_count`=3 (reads r0 in M1, M3 and M5).
- Same stuck-at fault with `BIST_STOP_ON_FAIL_EN` → `done` the cycle after the M1 read of address 5 is compared, `fail_count`=1.
- `start` held high for 20 cycles mid-run → ignored; still exactly one `done` pulse at cycle 162.
- `reset` asserted at cycle 50 of a run → all outputs take reset values asynchronously. A subsequent `start` completes normally with `pass`=1.
- Monitor the RAM bus throughout the run → write/read order, addresses and `ram_din` match the March C- table. No access is driven while `busy`=0.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types for the March C- BIST engine.
//   bist_state_e : FSM states
//   OP_WRITE/OP_READ : encoding of ram_write_read_en
//   march_elem() : per-element direction, read background and write background
package ram_bist_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} bist_state_e;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int NUM_ELEM = 6;
  localparam int ELEM_W   = 3;

  // Direction per element index: M3..M5 walk downwards. Bits 6/7 pad the
  // vector so any ELEM_W-bit index selects in range.
  localparam logic [7:0] ELEM_DOWN = 8'b0011_1000;

  // Backgrounds: 0 = PATTERN, 1 = ~PATTERN.
  typedef struct packed {
    logic down;
    logic has_rd;
    logic rd_bg;
    logic has_wr;
    logic wr_bg;
  } march_elem_t;

  function automatic march_elem_t march_elem(input logic [ELEM_W-1:0] idx);
    march_elem_t e;
    case (idx)
      3'd0:    e = '{down: 1'b0, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b0}; // up(w0)
      3'd1:    e = '{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1}; // up(r0,w1)
      3'd2:    e = '{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0}; // up(r1,w0)
      3'd3:    e = '{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1}; // dn(r0,w1)
      3'd4:    e = '{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0}; // dn(r1,w0)
      default: e = '{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0}; // dn(r0)
    endcase
    e.down = ELEM_DOWN[idx];
    return e;
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// ram_march_bist_if: single-port LUT RAM bus.
//   ram_write_read_en : 0 = write, 1 = read (initiator -> RAM)
//   ram_address       : word address (initiator -> RAM)
//   ram_din           : write data (initiator -> RAM)
//   ram_dout          : registered read data, valid the cycle after a read (RAM -> initiator)
interface ram_march_bist_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 11
);
  logic             ram_write_read_en;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  modport master (output ram_write_read_en, ram_address, ram_din, input  ram_dout);
  modport slave  (input  ram_write_read_en, ram_address, ram_din, output ram_dout);
endinterface

// File: rtl/ram_bist_checker.sv
// ram_bist_checker: compare stage of the BIST.
//   A read seen on the bus (rd_vld/rd_addr/rd_exp) is registered; the next
//   cycle its expected value is compared with ram_dout.
//   clear         : start of a new test, pass->1 and all fail state cleared
//   kill          : drop the read being registered this cycle (test aborted)
//   mismatch      : combinational, current compare failed
//   pass, fail_addr, fail_syndrome, fail_count : registered results
module ram_bist_checker #(
  parameter int WIDTH = 32,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             kill,
  input  logic             rd_vld,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_exp,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             mismatch,
  output logic             pass,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_syndrome,
  output logic [15:0]      fail_count
);

  logic             cmp_vld_q;
  logic [AW-1:0]    cmp_addr_q;
  logic [WIDTH-1:0] cmp_exp_q;

  assign mismatch = cmp_vld_q && (cmp_exp_q != ram_dout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_vld_q     <= 1'b0;
      cmp_addr_q    <= '0;
      cmp_exp_q     <= '0;
      pass          <= 1'b0;
      fail_addr     <= '0;
      fail_syndrome <= '0;
      fail_count    <= '0;
    end else if (clear) begin
      cmp_vld_q     <= 1'b0;
      pass          <= 1'b1;
      fail_addr     <= '0;
      fail_syndrome <= '0;
      fail_count    <= '0;
    end else begin
      cmp_vld_q  <= rd_vld && !kill;
      cmp_addr_q <= rd_addr;
      cmp_exp_q  <= rd_exp;
      if (mismatch) begin
        pass <= 1'b0;
        // count is saturating and never returns to 0, so 0 marks "first"
        if (fail_count == 16'h0000) begin
          fail_addr     <= cmp_addr_q;
          fail_syndrome <= cmp_exp_q ^ ram_dout;
        end
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- built-in self test for a single-port RAM.
//   clk, reset (async, active low), start (sampled in IDLE)
//   busy, done, pass, fail_addr, fail_syndrome, fail_count : status/results
//   ram : RAM bus (master side), held at idle values while busy = 0
// Optional: define BIST_STOP_ON_FAIL_EN to end the test on the first mismatch.
//
// The element/address/phase counters describe the operation to issue next;
// the bus registers load it one edge later, so busy and the first M0 write
// appear one cycle after start is sampled. During reads ram_din carries the
// expected background (the RAM ignores din on reads), which lets the checker
// take its expected value straight off the bus.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2048,
  parameter logic [WIDTH-1:0] PATTERN = 32'h0000_0000,
  localparam int              AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW-1:0]     fail_addr,
  output logic [WIDTH-1:0]  fail_syndrome,
  output logic [15:0]       fail_count,
  ram_march_bist_if.master  ram
);

`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  bist_state_e       state_q, state_d;
  logic [ELEM_W-1:0] elem_q;
  logic [AW-1:0]     addr_q;
  logic              phase_q;   // 0 = read slot, 1 = write slot of an r/w element

  march_elem_t       el;
  logic              op_rd, addr_end, addr_done, elem_done, seq_done;
  logic              next_down;
  logic [WIDTH-1:0]  op_data;
  logic              launch, advance, abort, mismatch;

  // decode of the current operation
  always_comb begin
    el        = march_elem(elem_q);
    op_rd     = el.has_rd && !(el.has_wr && phase_q);
    op_data   = (op_rd ? el.rd_bg : el.wr_bg) ? ~PATTERN : PATTERN;
    addr_end  = el.down ? (addr_q == '0) : (addr_q == AW'(DEPTH - 1));
    addr_done = !(el.has_rd && el.has_wr) || phase_q;
    elem_done = addr_end && addr_done;
    seq_done  = elem_done && (elem_q == ELEM_W'(NUM_ELEM - 1));
    next_down = ELEM_DOWN[elem_q + ELEM_W'(1)];
  end

  assign abort = STOP_ON_FAIL && mismatch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // CHECK covers the cycle the last read sits on the bus, DONE the cycle of
  // its compare; the done pulse is registered from DONE.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) begin
                 state_d = S_RUN;
                 launch  = 1'b1;
               end
      S_RUN:   begin
                 advance = 1'b1;
                 if (seq_done) state_d = S_CHECK;
               end
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      advance = 1'b0;
      launch  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_q                <= '0;
      addr_q                <= '0;
      phase_q               <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      ram.ram_write_read_en <= OP_READ;
      ram.ram_address       <= '0;
      ram.ram_din           <= '0;
    end else begin
      if (launch) begin
        elem_q  <= '0;
        addr_q  <= '0;
        phase_q <= 1'b0;
      end else if (advance) begin
        if (!addr_done) begin
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (!elem_done)     addr_q <= el.down ? addr_q - AW'(1) : addr_q + AW'(1);
          else if (!seq_done) begin
            elem_q <= elem_q + ELEM_W'(1);
            addr_q <= next_down ? AW'(DEPTH - 1) : '0;
          end
        end
      end

      if (advance) begin
        busy                  <= 1'b1;
        ram.ram_write_read_en <= op_rd ? OP_READ : OP_WRITE;
        ram.ram_address       <= addr_q;
        ram.ram_din           <= op_data;
      end else begin
        busy                  <= 1'b0;
        ram.ram_write_read_en <= OP_READ;
        ram.ram_address       <= '0;
        ram.ram_din           <= '0;
      end

      done <= (state_q == S_DONE) || abort;
    end
  end

  ram_bist_checker #(.WIDTH(WIDTH), .AW(AW)) u_chk (
    .clk           (clk),
    .reset         (reset),
    .clear         (launch),
    .kill          (abort),
    .rd_vld        (busy && (ram.ram_write_read_en == OP_READ)),
    .rd_addr       (ram.ram_address),
    .rd_exp        (ram.ram_din),
    .ram_dout      (ram.ram_dout),
    .mismatch      (mismatch),
    .pass          (pass),
    .fail_addr     (fail_addr),
    .fail_syndrome (fail_syndrome),
    .fail_count    (fail_count)
  );

endmodule

// File: tb/tb_ram_march_bist.sv
`timescale 1ns/1ps
module tb_ram_march_bist;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int N_OPS = 10 * DEPTH;
  localparam logic [WIDTH-1:0] PAT = 32'h0000_0000;
`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic busy, done, pass;
  logic [AW-1:0]    fail_addr;
  logic [WIDTH-1:0] fail_syndrome;
  logic [15:0]      fail_count;

  ram_march_bist_if #(.WIDTH(WIDTH), .AW(AW)) ram_if ();

  ram_march_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_syndrome(fail_syndrome), .fail_count(fail_count),
    .ram(ram_if)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- RAM model with up to two stuck-at bit faults ----
  typedef struct { bit en; int addr; int bitn; bit val; } fault_t;
  fault_t flt [2];
  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic [WIDTH-1:0] faulty(input int a, input logic [WIDTH-1:0] v);
    for (int f = 0; f < 2; f++)
      if (flt[f].en && flt[f].addr == a) v[flt[f].bitn] = flt[f].val;
    return v;
  endfunction

  initial begin
    ram_if.ram_dout = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (ram_if.ram_write_read_en) ram_if.ram_dout <= faulty(int'(ram_if.ram_address), mem[ram_if.ram_address]);
    else                          mem[ram_if.ram_address] <= ram_if.ram_din;
  end

  // ---- March C- as a list of elements: direction, ops (1=read), backgrounds ----
  int el_dir [6]    = '{0, 0, 0, 1, 1, 1};
  int el_n   [6]    = '{1, 2, 2, 2, 2, 1};
  bit el_k   [6][2] = '{'{0,0}, '{1,0}, '{1,0}, '{1,0}, '{1,0}, '{1,0}};
  bit el_v   [6][2] = '{'{0,0}, '{0,1}, '{1,0}, '{0,1}, '{1,0}, '{0,0}};

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [WIDTH-1:0] din; } bus_t;
  typedef struct { int done_cyc; bit pass; logic [AW-1:0] faddr; logic [WIDTH-1:0] syn; int cnt; } res_t;
  bus_t bus_q [$];
  res_t res_q [$];
  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Build the expected bus trace and result, then pulse start.
  task automatic run_start();
    bus_t ops [$];
    logic [WIDTH-1:0] m [DEPTH];
    logic [WIDTH-1:0] rd;
    res_t r;
    int last, k, a;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < DEPTH; i++) begin
        a = el_dir[e] ? DEPTH - 1 - i : i;
        for (int j = 0; j < el_n[e]; j++)
          ops.push_back('{we: el_k[e][j], addr: AW'(a), din: el_v[e][j] ? ~PAT : PAT});
      end
    last = N_OPS - 1;
    r.pass = 1; r.cnt = 0; r.faddr = '0; r.syn = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (!ops[i].we) m[ops[i].addr] = ops[i].din;
      else begin
        rd = faulty(int'(ops[i].addr), m[ops[i].addr]);
        if (rd !== ops[i].din) begin
          if (r.cnt == 0) begin r.faddr = ops[i].addr; r.syn = rd ^ ops[i].din; end
          r.cnt++;
          r.pass = 0;
          if (STOP) begin last = i; break; end
        end
      end
    end
    // the op after the failing read is already on the bus when the abort hits
    for (int i = 0; i <= ((last + 1 < N_OPS) ? last + 1 : N_OPS - 1); i++) bus_q.push_back(ops[i]);
    k = cyc + 1;
    r.done_cyc = k + last + 3;
    res_q.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (res_q.size() != 0 && t < 30 * DEPTH) begin @(negedge clk); t++; end
    if (res_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", t);
      res_q.delete();
    end
    repeat (3) @(negedge clk);
    check("bus_drain", 64'(bus_q.size()), 64'd0);
    bus_q.delete();
  endtask

  task automatic check_reset_vals();
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_pass",  64'(pass), 64'd0);
    check("rst_faddr", 64'(fail_addr), 64'd0);
    check("rst_syn",   64'(fail_syndrome), 64'd0);
    check("rst_cnt",   64'(fail_count), 64'd0);
    check("rst_bus",   64'({ram_if.ram_write_read_en, ram_if.ram_address, ram_if.ram_din}),
          64'({1'b1, {AW{1'b0}}, {WIDTH{1'b0}}}));
  endtask

  task automatic clear_faults();
    for (int f = 0; f < 2; f++) flt[f] = '{en: 0, addr: 0, bitn: 0, val: 0};
  endtask

  // ---- monitor: bus trace and completion results ----
  bus_t eb;
  res_t er;
  always @(negedge clk) begin
    if (busy) begin
      if (bus_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL bus_extra: unexpected access we=%0b addr=%0h", ram_if.ram_write_read_en, ram_if.ram_address);
      end else begin
        eb = bus_q.pop_front();
        check("bus_op", 64'({ram_if.ram_write_read_en, ram_if.ram_address, ram_if.ram_din}), 64'(eb));
      end
    end else begin
      check("bus_idle", 64'({ram_if.ram_write_read_en, ram_if.ram_address, ram_if.ram_din}),
            64'({1'b1, {AW{1'b0}}, {WIDTH{1'b0}}}));
    end
    if (done) begin
      if (res_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL done_extra: unexpected done pulse at cycle %0d", cyc);
      end else begin
        er = res_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(er.done_cyc));
        check("done_busy",  64'(busy), 64'd0);
        check("pass",       64'(pass), 64'(er.pass));
        check("fail_addr",  64'(fail_addr), 64'(er.faddr));
        check("fail_syn",   64'(fail_syndrome), 64'(er.syn));
        check("fail_count", 64'(fail_count), 64'(er.cnt));
      end
    end
  end

  initial begin
    clear_faults();
    repeat (3) @(negedge clk);
    #3 check_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free run
    run_start();
    wait_done();

    // stuck-at-1 on bit 3 of address 5
    flt[0] = '{en: 1, addr: 5, bitn: 3, val: 1};
    run_start();
    wait_done();
    clear_faults();

    // start held high for 20 cycles mid-run is ignored
    run_start();
    repeat (30) @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done();

    // asynchronous reset at cycle 50 of a run
    run_start();
    repeat (49) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    bus_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_start();
    wait_done();

    // randomized fault sets and idle gaps
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      for (int f = 0; f < int'($urandom_range(0, 2)); f++)
        flt[f] = '{en: 1, addr: int'($urandom_range(0, DEPTH - 1)),
                   bitn: int'($urandom_range(0, WIDTH - 1)), val: 1'($urandom)};
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_start();
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
